fifo_rd_packer: RTL and testbench
=================================

// Module: fifo_rd_packer
// PURPOSE
//   Read-side consumer for the dual-clock FIFO. Runs entirely in the read clock domain.
//   Pops DSIZE-bit words via rdata/rempty/rinc and packs PACK consecutive words into one wide beat.
//   Presents each beat on a valid/ready stream; a flush request emits a partial beat with per-lane keep.
//   The fill register and the output register are separate, so filling continues while a beat waits for out_ready.
// PARAMETERS
//   DSIZE  8  width of one FIFO word; must equal the FIFO data width
//   PACK   4  FIFO words per output beat, >= 1; count register is $clog2(PACK+1) bits
// PORTS
//   rclk      in   1           read-domain clock, all logic rising-edge
//   rrst      in   1           asynchronous, active-high reset
//   rdata     in   DSIZE       FIFO word at the current read pointer; valid whenever rempty=0
//   rempty    in   1           FIFO empty flag
//   rinc      out  1           pop strobe; the word on rdata is consumed on this edge
//   flush     in   1           one-cycle request to emit the current partial beat
//   out_data  out  DSIZE*PACK  packed beat; first-popped word in lane 0 (bits DSIZE-1:0)
//   out_keep  out  PACK        lane i holds a valid word
//   out_valid out  1           beat present
//   out_ready in   1           downstream accepts the beat on this edge when out_valid=1
//   busy      out  1           (cnt != 0) | out_valid | flush_pend
// BEHAVIOUR
//   Reset: while rrst=1, all registers clear asynchronously: cnt=0, fill=0, flush_pend=0.
//     Outputs under reset: out_valid=0, out_data=0, out_keep=0, busy=0; rinc is forced 0.
//   Reset mid-operation discards any partially filled or held beat; unpopped FIFO words stay in the FIFO.
//   Internal state:
//     fill register with cnt words held (0..PACK);
//     flush_pend flag;
//     output register (out_data, out_keep, out_valid).
//   Pop enable: out_free = ~out_valid | out_ready.
//   Transfer condition: xfer = out_free & ((cnt==PACK) | (flush_pend & cnt!=0)).
//   Pop strobe: rinc = ~rrst & ~rempty & ~flush_pend & ((cnt<PACK) | xfer).
//   On rinc, rdata is written into lane (xfer ? 0 : cnt).
//   Next count: cnt_next = (xfer ? 0 : cnt) + rinc.
//   On xfer:
//     out_data = fill, with lanes >= cnt driven to zero;
//     out_keep = (1<<cnt)-1;
//     out_valid = 1;
//     flush_pend clears.
//   On out_valid & out_ready & ~xfer: out_valid clears. out_data and out_keep hold their last value.
//   While out_valid=1 and out_ready=0, out_data and out_keep are stable.
//   flush sets flush_pend only if (cnt!=0 | rinc) in that cycle; otherwise flush is ignored.
//     A word popped in the flush cycle belongs to the flushed beat.
//     rinc stays low from the cycle after flush until the partial beat transfers.
//     flush while flush_pend=1 has no further effect.
//   Latency: the last word of a beat is popped at edge E; xfer occurs at E+1; out_valid is seen after E+1.
//   Throughput: 1 word/cycle sustained for any PACK with out_ready=1 and rempty=0; no bubbles at beat boundaries.
//   Full backpressure: at most 2*PACK words are popped before rinc stops (one beat held, one beat filled).
//   rempty=1: no pop, no state change except pending transfers or out_ready handshakes.
//   PACK=1: each pop fills the register; the next pop coincides with xfer.
// TESTING
//   1. PACK=4, out_ready=1, FIFO presents 0x11,0x22,0x33,0x44
//      -> 4 rinc pulses; one beat with out_data=0x44332211, out_keep=4'b1111.
//   2. out_ready=0, 12 words available
//      -> rinc stops after 8 pops; out_data is stable at beat 0.
//      Release out_ready -> beats 0, 1, 2 in order, no loss or duplication.
//   3. Words 0xA1,0xB2 then flush
//      -> out_data=0x0000B2A1, out_keep=4'b0011; rinc low until transfer; next beat starts in lane 0.
//   4. flush with cnt=0 and rempty=1
//      -> no beat, flush_pend stays 0, busy stays 0.
//   5. rrst pulsed mid-cycle after 3 pops
//      -> out_valid, busy and rinc drop immediately.
//      After release, the next 4 words form a fresh beat (lane 0 = first post-reset word).
//   6. rempty toggling every cycle, random out_ready
//      -> rinc is never high while rempty=1; the beat stream equals the popped word sequence exactly.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer for the dual-clock FIFO. Pops DSIZE-bit words and packs PACK of
// them into one valid/ready beat. A flush emits the partial beat with per-lane keep.
module fifo_rd_packer #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned PACK  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DSIZE-1:0]      rdata,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic                  flush,
  output logic [DSIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(PACK + 1);
  localparam int unsigned BW = DSIZE * PACK;

  logic [PACK-1:0][DSIZE-1:0] fill;
  logic [CW-1:0]              cnt;
  logic [CW-1:0]              wr_lane;
  logic [CW-1:0]              cnt_next;
  logic                       flush_pend;
  logic                       out_free;
  logic                       xfer;
  logic                       cnt_nz;
  logic                       full;
  logic [PACK-1:0]            keep_next;
  logic [BW-1:0]              data_next;

  // Handshake, pop and transfer decisions
  always_comb begin
    cnt_nz   = (cnt != '0);
    full     = (cnt == CW'(PACK));
    out_free = ~out_valid | out_ready;
    xfer     = out_free & (full | (flush_pend & cnt_nz));
    rinc     = ~rrst & ~rempty & ~flush_pend & ((cnt < CW'(PACK)) | xfer);
    wr_lane  = xfer ? '0 : cnt;
    cnt_next = wr_lane + CW'(rinc);
  end

  // Beat image: only the lanes holding words are kept, the rest read as zero
  always_comb begin
    keep_next = '0;
    data_next = '0;
    for (int unsigned i = 0; i < PACK; i++) begin
      keep_next[i]              = (CW'(i) < cnt);
      data_next[i*DSIZE +: DSIZE] = keep_next[i] ? fill[i] : '0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      fill <= '0;
      cnt  <= '0;
    end else begin
      for (int unsigned i = 0; i < PACK; i++) begin
        if (rinc && (wr_lane == CW'(i))) fill[i] <= rdata;
      end
      cnt <= cnt_next;
    end
  end

  // A flush coinciding with a transfer only applies to a word popped in that same cycle
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      flush_pend <= 1'b0;
    end else if (xfer) begin
      flush_pend <= flush & rinc;
    end else if (flush && (cnt_nz || rinc)) begin
      flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= data_next;
      out_keep  <= keep_next;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = cnt_nz | out_valid | flush_pend;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO and word-stream scoreboard, directed
// scenarios followed by randomized traffic with backpressure, empty gaps and flushes.
module tb_fifo_rd_packer;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned PACK  = 4;
  localparam int unsigned BW    = DSIZE * PACK;

  logic             rclk = 1'b0;
  logic             rrst;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             flush;
  logic [BW-1:0]    out_data;
  logic [PACK-1:0]  out_keep;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK)) dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_keep(out_keep), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 rclk = ~rclk;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] popped[$];
  logic [BW-1:0]    log_d[$];
  logic [PACK-1:0]  log_k[$];
  int               errors = 0;
  int               checks = 0;
  int               npop   = 0;
  int               npush  = 0;
  int               base;
  bit               full_mode;
  bit               last_rinc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    npush++;
  endtask

  task automatic drive_fifo(input bit hold_empty);
    rempty = hold_empty | (fifo_q.size() == 0);
    rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One read-clock cycle, entered and left on a falling edge
  task automatic step(input bit rdy, input bit fl, input bit hold_empty);
    bit               pop, acc, held;
    logic [BW-1:0]    hd, ed;
    logic [PACK-1:0]  hk, ek;
    int               k, avail;
    out_ready = rdy;
    flush     = fl;
    drive_fifo(hold_empty);
    #1;
    pop       = rinc;
    last_rinc = rinc;
    acc       = out_valid & out_ready;
    held      = out_valid & ~out_ready;
    hd        = out_data;
    hk        = out_keep;
    if (rempty) check("rinc_on_empty", 64'(rinc), 64'd0);
    if (acc) begin
      k     = $countones(out_keep);
      avail = popped.size();
      ed    = '0;
      for (int i = 0; i < k; i++) begin
        if (popped.size() != 0) ed[i*DSIZE +: DSIZE] = popped.pop_front();
      end
      ek = full_mode ? {PACK{1'b1}} : PACK'((1 << k) - 1);
      check("beat_words", 64'((avail >= k) && (k > 0)), 64'd1);
      check("beat_keep", 64'(out_keep), 64'(ek));
      check("beat_data", 64'(out_data), 64'(ed));
      log_d.push_back(out_data);
      log_k.push_back(out_keep);
    end
    @(posedge rclk);
    if (pop) begin
      popped.push_back(fifo_q.pop_front());
      npop++;
    end
    @(negedge rclk);
    if (held) check("hold_stable", 64'({out_valid, out_keep, out_data}), 64'({1'b1, hk, hd}));
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(rdy, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rrst = 1'b0; flush = 1'b0; out_ready = 1'b0; rempty = 1'b0; rdata = 8'h5A;
    full_mode = 1'b1;
    #1 rrst = 1'b1;
    #1;
    check("rst_rinc", 64'(rinc), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_keep", 64'(out_keep), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;

    // Basic packing
    log_d.delete(); log_k.delete();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    base = npop;
    run(4, 1'b1);
    check("t1_pops", 64'(npop - base), 64'd4);
    run(4, 1'b1);
    check("t1_beats", 64'(log_d.size()), 64'd1);
    if (log_d.size() != 0) begin
      check("t1_data", 64'(log_d[0]), 64'h44332211);
      check("t1_keep", 64'(log_k[0]), 64'hF);
    end
    check("t1_idle", 64'(busy), 64'd0);

    // Sustained throughput across beat boundaries
    log_d.delete(); log_k.delete();
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    base = npop;
    run(16, 1'b1);
    check("tput_pops", 64'(npop - base), 64'd16);
    run(4, 1'b1);
    check("tput_beats", 64'(log_d.size()), 64'd4);

    // Full backpressure
    log_d.delete(); log_k.delete();
    for (int i = 0; i < 12; i++) push(8'(8'h60 + i));
    base = npop;
    run(15, 1'b0);
    check("bp_pops", 64'(npop - base), 64'd8);
    check("bp_held", 64'(out_data), 64'h63626160);
    run(20, 1'b1);
    check("bp_beats", 64'(log_d.size()), 64'd3);
    if (log_d.size() == 3) begin
      check("bp_b1", 64'(log_d[1]), 64'h67666564);
      check("bp_b2", 64'(log_d[2]), 64'h6B6A6968);
    end
    check("bp_pops_all", 64'(npop - base), 64'd12);

    // Partial beat via flush
    full_mode = 1'b0;
    log_d.delete(); log_k.delete();
    push(8'hA1); push(8'hB2);
    run(2, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    push(8'hC3); push(8'hD4); push(8'hE5); push(8'hF6);
    step(1'b1, 1'b0, 1'b0);
    check("fl_rinc_low", 64'(last_rinc), 64'd0);
    run(8, 1'b1);
    check("fl_beats", 64'(log_d.size()), 64'd2);
    if (log_d.size() == 2) begin
      check("fl_data", 64'(log_d[0]), 64'h0000B2A1);
      check("fl_keep", 64'(log_k[0]), 64'h3);
      check("fl_next", 64'(log_d[1]), 64'hF6E5D4C3);
      check("fl_next_keep", 64'(log_k[1]), 64'hF);
    end

    // Flush while idle is ignored
    log_d.delete(); log_k.delete();
    step(1'b1, 1'b1, 1'b0);
    check("idle_fl_busy", 64'(busy), 64'd0);
    run(3, 1'b1);
    check("idle_fl_nobeat", 64'(log_d.size()), 64'd0);
    full_mode = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
    run(7, 1'b1);
    check("idle_fl_after", 64'(log_d.size()), 64'd1);

    // Reset in the middle of a beat
    log_d.delete(); log_k.delete();
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i));
    run(3, 1'b1);
    drive_fifo(1'b0);
    #1;
    check("mr_busy_pre", 64'(busy), 64'd1);
    rrst = 1'b1;
    #2;
    check("mr_rinc", 64'(rinc), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_valid", 64'(out_valid), 64'd0);
    @(posedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    popped.delete();
    run(6, 1'b1);
    check("mr_beats", 64'(log_d.size()), 64'd1);
    if (log_d.size() != 0) check("mr_data", 64'(log_d[0]), 64'h86858483);
    full_mode = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    run(3, 1'b1);
    check("mr_tail", 64'(log_d.size()), 64'd2);
    if (log_d.size() == 2) begin
      check("mr_tail_data", 64'(log_d[1]), 64'h00000087);
      check("mr_tail_keep", 64'(log_k[1]), 64'h1);
    end

    // Random traffic: empty toggling, random ready, occasional flush
    for (int c = 0; c < 800; c++) begin
      if (($urandom_range(0, 2) != 0) && (fifo_q.size() < 20)) push(8'($urandom));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), c[0]);
    end
    for (int c = 0; c < 200; c++) begin
      if ((fifo_q.size() == 0) && (popped.size() == 0) && !busy) break;
      step(1'b1, (c % 8) == 0, 1'b0);
    end
    check("drain_fifo", 64'(fifo_q.size()), 64'd0);
    check("drain_sb", 64'(popped.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);
    check("pop_total", 64'(npop), 64'(npush));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
